// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial-adder arbiter slice: default widths,
// burst depth and the sequencer state encoding.
package serial_adder_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int DATA_W_DEF   = 12;
  localparam int BURST_DEF    = 8;
  localparam int SUM_W_DEF    = DATA_W_DEF + $clog2(BURST_DEF);
  localparam int WAIT_MAX_DEF = 16;
  localparam int ID_W         = $clog2(NUM_REQ_DEF);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT} state_t;

endpackage

// File: rtl/serial_adder_arbiter_rr_pick.sv
// Combinational round-robin pick: first requesting lane at or after rr_ptr,
// wrapping, returned both as a one-hot grant and as an index.
module rr_pick
  import serial_adder_pkg::*;
#(
  parameter int N  = NUM_REQ_DEF,
  parameter int IW = ID_W
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(rr_ptr) + k) % N);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/serial_adder_arbiter.sv
// Round-robin sequencer sharing one signed serial adder among NUM_REQ lanes:
// streams a fixed burst from the granted lane, then returns the tagged sum.
module serial_adder_arbiter
  import serial_adder_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BURST    = BURST_DEF,
  parameter int SUM_W    = DATA_W + $clog2(BURST),
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_n,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        add_enable,
  output logic signed [DATA_W-1:0]    add_n,
  input  logic signed [SUM_W-1:0]     add_sum,
  input  logic                        add_sum_valid,
  output logic                        res_valid,
  output logic [$clog2(NUM_REQ)-1:0]  res_id,
  output logic signed [SUM_W-1:0]     res_sum,
  output logic                        res_err
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST);
  localparam int TMO_W = $clog2(WAIT_MAX);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(BURST - 1);
  localparam logic [TMO_W-1:0] LAST_WAIT   = TMO_W'(WAIT_MAX - 1);
  localparam logic [IW-1:0]    LAST_LANE   = IW'(NUM_REQ - 1);

  state_t             state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [CNT_W-1:0]   cnt;
  logic [TMO_W-1:0]   tmo;

  function automatic logic signed [DATA_W-1:0] lane_sample(
    input logic [NUM_REQ*DATA_W-1:0] lanes,
    input logic [IW-1:0]             i
  );
    return $signed(DATA_W'(lanes >> (int'(i) * DATA_W)));
  endfunction

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      gnt_idx    <= '0;
      rr_ptr     <= '0;
      cnt        <= '0;
      tmo        <= '0;
      add_enable <= 1'b0;
      add_n      <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_sum    <= '0;
      res_err    <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= pick_gnt;
            gnt_idx <= pick_idx;
            cnt     <= '0;
            state   <= STREAM;
          end
        end
        // Samples are registered, so the adder sees them one cycle behind gnt.
        STREAM: begin
          add_n      <= lane_sample(req_n, gnt_idx);
          add_enable <= 1'b1;
          cnt        <= cnt + 1'b1;
          if (cnt == LAST_SAMPLE) begin
            gnt    <= '0;
            rr_ptr <= (gnt_idx == LAST_LANE) ? '0 : gnt_idx + 1'b1;
            tmo    <= '0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          add_enable <= 1'b0;
          add_n      <= '0;
          tmo        <= tmo + 1'b1;
          if (add_sum_valid) begin
            res_valid <= 1'b1;
            res_id    <= gnt_idx;
            res_sum   <= add_sum;
            res_err   <= 1'b0;
            state     <= IDLE;
          end else if (tmo == LAST_WAIT) begin
            res_valid <= 1'b1;
            res_id    <= gnt_idx;
            res_sum   <= '0;
            res_err   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Bench for serial_adder_arbiter: lane producers, a behavioural adder and a
// round-robin reference model driving directed and randomized bursts.
module tb_serial_adder_arbiter;

  localparam int N    = 4;
  localparam int DW   = 12;
  localparam int B    = 8;
  localparam int SW   = 15;
  localparam int WMAX = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         req = '0;
  logic [N*DW-1:0]      req_n = '0;
  logic [N-1:0]         gnt;
  logic                 add_enable;
  logic signed [DW-1:0] add_n;
  logic signed [SW-1:0] add_sum;
  logic                 add_sum_valid;
  logic                 res_valid;
  logic [1:0]           res_id;
  logic signed [SW-1:0] res_sum;
  logic                 res_err;

  always #5 clk = ~clk;

  serial_adder_arbiter #(
    .NUM_REQ  (N),
    .DATA_W   (DW),
    .BURST    (B),
    .SUM_W    (SW),
    .WAIT_MAX (WMAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_n         (req_n),
    .gnt           (gnt),
    .add_enable    (add_enable),
    .add_n         (add_n),
    .add_sum       (add_sum),
    .add_sum_valid (add_sum_valid),
    .res_valid     (res_valid),
    .res_id        (res_id),
    .res_sum       (res_sum),
    .res_err       (res_err)
  );

  // Producers: lane i presents sample k during its k-th grant cycle.
  logic signed [DW-1:0] samples [N][B];
  int gcnt [N];

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        req_n[i*DW +: DW] = samples[i][gcnt[i] % B];
        gcnt[i]++;
      end else begin
        req_n[i*DW +: DW] = samples[i][0];
        gcnt[i] = 0;
      end
    end
  end

  // Behavioural adder: sums while enabled, answers resp_delay cycles after enable falls.
  int   acc = 0, nsamp = 0, last_len = 0, dly_cnt = 0, resp_delay = 1;
  int   low_run = 1000, gap_at_rise = 0;
  bit   was_en = 1'b0, pend = 1'b0, withhold = 1'b0, stray_vld = 1'b0;
  logic model_vld = 1'b0;
  logic signed [SW-1:0] model_sum = '0;

  assign add_sum_valid = model_vld | stray_vld;
  assign add_sum       = stray_vld ? 15'sh1234 : model_sum;

  always @(negedge clk) begin
    model_vld = 1'b0;
    if (add_enable) begin
      if (!was_en) gap_at_rise = low_run;
      acc += int'(add_n);
      nsamp++;
      was_en  = 1'b1;
      low_run = 0;
    end else begin
      low_run++;
      if (was_en) begin
        was_en    = 1'b0;
        last_len  = nsamp;
        model_sum = SW'(acc);
        acc       = 0;
        nsamp     = 0;
        pend      = !withhold;
        dly_cnt   = resp_delay;
      end
    end
    if (pend) begin
      if (dly_cnt == 0) begin
        model_vld = 1'b1;
        pend      = 1'b0;
      end else begin
        dly_cnt--;
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int exp_ptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (((m >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    return -1;
  endfunction

  function automatic int lane_sum(input int l);
    int s = 0;
    for (int k = 0; k < B; k++) s += int'(samples[l][k]);
    return s;
  endfunction

  // One arbitration round; called at a negedge while the DUT is idle or showing res_valid.
  task automatic do_burst(input logic [N-1:0] mask, input bit wh, input int dly,
                          input int stray_at, input string tag, output int g);
    int n, w, eg;
    logic [SW-1:0] es;
    req        = mask;
    withhold   = wh;
    resp_delay = dly;
    eg = rr_next(mask, exp_ptr);
    es = wh ? '0 : SW'(lane_sum(eg));
    g  = -1;
    n  = 0;
    @(negedge clk);
    chk({tag, "_res_pulse"}, 32'(res_valid), 32'd0);
    while (gnt == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_gnt"}, 32'(gnt), 32'(1 << eg));
    chk({tag, "_gnt_lat"}, n, 32'd0);
    if (gnt == '0) return;
    for (int i = 0; i < N; i++) if (gnt[i]) g = i;
    n = 0;
    do begin
      n++;
      stray_vld = (n == stray_at);
      if (n == 2 && mask != '1) req = '0;
      @(negedge clk);
    end while (gnt != '0 && n < 20);
    stray_vld = 1'b0;
    chk({tag, "_gnt_len"}, n, B);
    chk({tag, "_en_gap"}, 32'(gap_at_rise >= 1), 32'd1);
    exp_ptr = (eg + 1) % N;
    w = 1;
    while (!res_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_res_lat"}, w, wh ? WMAX + 1 : dly + 3);
    chk({tag, "_res_id"}, 32'(res_id), 32'(eg));
    chk({tag, "_res_err"}, 32'(res_err), 32'(wh));
    chk({tag, "_res_sum"}, 32'($unsigned(res_sum)), 32'(es));
    chk({tag, "_en_len"}, last_len, B);
    chk({tag, "_idle_n"}, 32'($unsigned(add_n)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n;
    bit seen;
    logic [N-1:0] m;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < B; k++) samples[i][k] = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_add_enable", 32'(add_enable), 32'd0);
    chk("rst_add_n", 32'($unsigned(add_n)), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_sum", 32'($unsigned(res_sum)), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    rst = 1'b0;

    samples[0][0] = 12'sd100; samples[0][1] = 12'sd500; samples[0][2] = 12'sd300;
    samples[0][3] = 12'sd400; samples[0][4] = 12'sd200; samples[0][5] = 12'sd656;
    samples[0][6] = 12'sd210; samples[0][7] = 12'sd247;
    do_burst(4'b0001, 1'b0, 1, -1, "lane0", g);
    chk("lane0_sum_const", 32'($unsigned(res_sum)), 32'h0A35);

    for (int k = 0; k < B; k++) samples[1][k] = 12'hFFF;
    do_burst(4'b0010, 1'b0, 0, -1, "lane1_neg", g);
    chk("lane1_sum_const", 32'($unsigned(res_sum)), 32'h7FF8);

    for (int k = 0; k < B; k++) samples[2][k] = 12'h800;
    do_burst(4'b0100, 1'b0, 2, -1, "lane2_min", g);
    chk("lane2_sum_const", 32'($unsigned(res_sum)), 32'h4000);

    for (int k = 0; k < B; k++) samples[3][k] = DW'($urandom);
    do_burst(4'b1000, 1'b0, 1, -1, "lane3", g);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < B; k++) samples[i][k] = DW'($urandom);
      do_burst(4'b1111, 1'b0, r % 3, -1, "all", g);
      chk("rr_order", g, r % N);
    end

    do_burst(4'b0010, 1'b1, 0, -1, "timeout", g);
    withhold = 1'b0;

    req = '0;
    @(negedge clk);
    stray_vld = 1'b1;
    @(negedge clk);
    stray_vld = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (res_valid || gnt != '0) seen = 1'b1;
    end
    chk("stray_idle", 32'(seen), 32'd0);

    do_burst(4'b0100, 1'b0, 2, 3, "stray_stream", g);
    do_burst(4'b0010, 1'b0, 1, -1, "pre_rst", g);

    req = '1;
    n = 0;
    @(negedge clk);
    while (gnt == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rst_burst_gnt", 32'(gnt), 32'b0100);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_add_enable", 32'(add_enable), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    chk("midrst_no_res", 32'(seen), 32'd0);
    exp_ptr = 0;
    do_burst(4'b1111, 1'b0, 1, -1, "post_rst", g);
    chk("post_rst_lane", g, 0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < B; k++) samples[i][k] = DW'($urandom);
      m = N'($urandom_range(1, 15));
      do_burst(m, 1'b0, $urandom_range(0, 5), $urandom_range(0, 8), "rand", g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
